// File: rtl/captura_de_numero_pkg.sv
// Shared types, key codes and the 4x4 keypad lookup for the number-capture path.
package captura_pkg;

  // Handshake FSM with the keypad scanner.
  typedef enum logic [1:0] {IDLE, ACK, APPLY, RELEASE} state_t;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
  localparam logic [3:0] KEY_A         = 4'd10;
  localparam logic [3:0] KEY_B         = 4'd11;
  localparam logic [3:0] KEY_C         = 4'd12;
  localparam logic [3:0] KEY_D         = 4'd13;
  localparam logic [3:0] KEY_STAR      = 4'd14;
  localparam logic [3:0] KEY_HASH      = 4'd15;

  // Key latched at capture time; invalid covers zero/multi-hot row or column.
  typedef struct packed {
    logic       invalid;
    logic [3:0] code;
  } key_t;

  // Row/column index pair to key code.
  //   row 0: 1 2 3 A | row 1: 4 5 6 B | row 2: 7 8 9 C | row 3: * 0 # D
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    case ({row, col})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = KEY_A;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = KEY_B;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'd0;
      4'hE: code = KEY_HASH;
      4'hF: code = KEY_D;
    endcase
    return code;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/captura_de_numero_if.sv
// Scanner handshake plus operand valid/ack bus of the number-capture block.
// master = scanner/downstream side, slave = captura_de_numero.
interface captura_de_numero_if #(
  parameter int WIDTH   = 4,
  parameter int VALUE_W = 10,
  parameter int CNT_W   = 2
);
  logic [WIDTH-1:0]   pressed_col_in;
  logic [WIDTH-1:0]   pressed_row_in;
  logic               pressed_valid;
  logic               ack_read;
  logic [3:0]         key_code;
  logic               key_strobe;
  logic               op_strobe;
  logic [VALUE_W-1:0] number_out;
  logic               number_valid;
  logic               number_ack;
  logic [CNT_W-1:0]   digit_count;
  logic               key_error;

  modport master (
    output pressed_col_in, pressed_row_in, pressed_valid, number_ack,
    input  ack_read, key_code, key_strobe, op_strobe, number_out,
           number_valid, digit_count, key_error
  );

  modport slave (
    input  pressed_col_in, pressed_row_in, pressed_valid, number_ack,
    output ack_read, key_code, key_strobe, op_strobe, number_out,
           number_valid, digit_count, key_error
  );
endinterface

// File: rtl/captura_de_numero_decodificador_tecla.sv
// Combinational keypad decoder: one-hot row/column to key code plus invalid flag.
// Kept standalone so the display path can reuse it.
module decodificador_tecla
  import captura_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] row_i,
  input  logic [WIDTH-1:0] col_i,
  output logic [3:0]       code_o,
  output logic             invalid_o
);
  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic       row_oh;
  logic       col_oh;

  // One-hot to index encoder; a multi-hot bus gives some index but is flagged invalid.
  always_comb begin
    row_idx = '0;
    col_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (row_i[i]) row_idx = 2'(i);
      if (col_i[i]) col_idx = 2'(i);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign row_oh    = (row_i != '0) && ((row_i & (row_i - WIDTH'(1))) == '0);
  assign col_oh    = (col_i != '0) && ((col_i & (col_i - WIDTH'(1))) == '0);
  assign code_o    = key_lookup(row_idx, col_idx);
  assign invalid_o = !(row_oh && col_oh);

endmodule

// File: rtl/captura_de_numero.sv
// Keypad number capture: handshakes latched keys from the scanner, accumulates
// decimal digits into a binary operand and offers it on a valid/ack interface.
module captura_de_numero
  import captura_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MAX_DIGITS = 3,
  parameter int VALUE_W    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  captura_de_numero_if.slave bus
);
  localparam int               CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam int               ACC_W   = VALUE_W + 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  if (WIDTH != 4) begin : g_bad_width
    $error("captura_de_numero: keypad map is 4x4, WIDTH must be 4");
  end
  if ((2 ** VALUE_W) <= ((10 ** MAX_DIGITS) - 1)) begin : g_bad_value_w
    $error("captura_de_numero: VALUE_W too narrow for MAX_DIGITS decimal digits");
  end

  state_t             state_q, state_d;
  key_t               key_q, key_d;
  logic               ack_read_q, ack_read_d;
  logic [3:0]         key_code_q, key_code_d;
  logic               key_strobe_q, key_strobe_d;
  logic               op_strobe_q, op_strobe_d;
  logic               key_error_q, key_error_d;
  logic [VALUE_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [VALUE_W-1:0] number_q, number_d;
  logic               number_valid_q, number_valid_d;

  logic [3:0]         dec_code;
  logic               dec_invalid;
  logic [ACC_W-1:0]   acc_w;
  logic [VALUE_W-1:0] acc_shifted;
  logic               nv_after_ack;

  decodificador_tecla #(.WIDTH(WIDTH)) u_dec (
    .row_i    (bus.pressed_row_in),
    .col_i    (bus.pressed_col_in),
    .code_o   (dec_code),
    .invalid_o(dec_invalid)
  );

  // acc*10 + digit as shift-and-add in a widened copy, truncated back.
  assign acc_w       = ACC_W'(acc_q);
  assign acc_shifted = VALUE_W'((acc_w << 3) + (acc_w << 1) + ACC_W'(key_q.code));

  // A downstream ack is applied before a same-edge commit, so it frees the slot.
  assign nv_after_ack = number_valid_q & ~bus.number_ack;

  // Next-state and key execution; the key takes effect on the ACK->APPLY edge so
  // strobes and the committed operand are visible while in APPLY.
  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    ack_read_d     = 1'b0;
    key_code_d     = key_code_q;
    key_strobe_d   = 1'b0;
    op_strobe_d    = 1'b0;
    key_error_d    = 1'b0;
    acc_d          = acc_q;
    count_d        = count_q;
    number_d       = number_q;
    number_valid_d = nv_after_ack;

    unique case (state_q)
      IDLE: begin
        if (bus.pressed_valid) begin
          key_d      = '{invalid: dec_invalid, code: dec_code};
          ack_read_d = 1'b1;
          state_d    = ACK;
        end
      end

      ACK: begin
        state_d = APPLY;
        if (key_q.invalid) begin
          key_error_d = 1'b1;
        end else begin
          key_strobe_d = 1'b1;
          key_code_d   = key_q.code;
          if (is_digit(key_q.code)) begin
            if (count_q < MAX_CNT) begin
              acc_d   = acc_shifted;
              count_d = count_q + CNT_W'(1);
            end else begin
              key_error_d = 1'b1;
            end
          end else if (key_q.code == KEY_STAR) begin
            acc_d   = '0;
            count_d = '0;
          end else if (key_q.code == KEY_HASH) begin
            if ((count_q != '0) && !nv_after_ack) begin
              number_d       = acc_q;
              number_valid_d = 1'b1;
              acc_d          = '0;
              count_d        = '0;
            end else begin
              key_error_d = 1'b1;
            end
          end else begin
            op_strobe_d = 1'b1;
          end
        end
      end

      APPLY: state_d = RELEASE;

      // Wait for the scanner to drop its latch so a held key is taken only once.
      RELEASE: begin
        if (!bus.pressed_valid) state_d = IDLE;
      end
    endcase
  end

  // State and output registers; async reset aborts any handshake in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      key_q          <= '0;
      ack_read_q     <= 1'b0;
      key_code_q     <= '0;
      key_strobe_q   <= 1'b0;
      op_strobe_q    <= 1'b0;
      key_error_q    <= 1'b0;
      acc_q          <= '0;
      count_q        <= '0;
      number_q       <= '0;
      number_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_q          <= key_d;
      ack_read_q     <= ack_read_d;
      key_code_q     <= key_code_d;
      key_strobe_q   <= key_strobe_d;
      op_strobe_q    <= op_strobe_d;
      key_error_q    <= key_error_d;
      acc_q          <= acc_d;
      count_q        <= count_d;
      number_q       <= number_d;
      number_valid_q <= number_valid_d;
    end
  end

  assign bus.ack_read     = ack_read_q;
  assign bus.key_code     = key_code_q;
  assign bus.key_strobe   = key_strobe_q;
  assign bus.op_strobe    = op_strobe_q;
  assign bus.key_error    = key_error_q;
  assign bus.number_out   = number_q;
  assign bus.number_valid = number_valid_q;
  assign bus.digit_count  = count_q;

endmodule

// File: tb/tb_captura_de_numero.sv
// Bench for captura_de_numero: directed table, hand-built corner sequences and
// randomized key presses against a decimal-arithmetic reference model.
module tb_captura_de_numero;
  localparam int WIDTH = 4, MAX_DIGITS = 3, VALUE_W = 10, CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  captura_de_numero_if #(.WIDTH(WIDTH), .VALUE_W(VALUE_W), .CNT_W(CNT_W)) bus ();

  captura_de_numero #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS), .VALUE_W(VALUE_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
  int m_acc, m_cnt, m_num, m_nv, m_code;

  function automatic void model_reset();
    m_acc = 0; m_cnt = 0; m_num = 0; m_nv = 0; m_code = 0;
  endfunction

  function automatic void model_press(input logic [3:0] r, input logic [3:0] c,
                                      output int e_str, output int e_op, output int e_err);
    int ri, ci, k;
    e_str = 0; e_op = 0; e_err = 0;
    if ($countones(r) != 1 || $countones(c) != 1) begin
      e_err = 1;
      return;
    end
    ri = 0; ci = 0;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) ri = i;
      if (c[i]) ci = i;
    end
    k = keymap[ri][ci];
    e_str = 1;
    m_code = k;
    if (k <= 9) begin
      if (m_cnt < MAX_DIGITS) begin m_acc = m_acc * 10 + k; m_cnt++; end
      else e_err = 1;
    end else if (k == 14) begin
      m_acc = 0; m_cnt = 0;
    end else if (k == 15) begin
      if (m_cnt > 0 && m_nv == 0) begin m_num = m_acc; m_nv = 1; m_acc = 0; m_cnt = 0; end
      else e_err = 1;
    end else begin
      e_op = 1;
    end
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0001;
    return v << i;
  endfunction

  // Scanner: present a key for 'hold' edges, then drop it and let the FSM settle,
  // counting every pulse seen on the way.
  task automatic press(input logic [3:0] r, input logic [3:0] c, input int hold,
                       output int n_ack, output int n_str, output int n_op, output int n_err);
    n_ack = 0; n_str = 0; n_op = 0; n_err = 0;
    @(negedge clk);
    bus.pressed_row_in = r;
    bus.pressed_col_in = c;
    bus.pressed_valid  = 1'b1;
    for (int i = 0; i < hold + 5; i++) begin
      @(negedge clk);
      n_ack += int'(bus.ack_read);
      n_str += int'(bus.key_strobe);
      n_op  += int'(bus.op_strobe);
      n_err += int'(bus.key_error);
      if (i == hold - 1) bus.pressed_valid = 1'b0;
    end
  endtask

  task automatic press_model(input logic [3:0] r, input logic [3:0] c, input int hold, input string tag);
    int n_ack, n_str, n_op, n_err, e_str, e_op, e_err;
    press(r, c, hold, n_ack, n_str, n_op, n_err);
    model_press(r, c, e_str, e_op, e_err);
    chk({tag, "_ack"},    n_ack, 1);
    chk({tag, "_strobe"}, n_str, e_str);
    chk({tag, "_op"},     n_op, e_op);
    chk({tag, "_err"},    n_err, e_err);
    chk({tag, "_code"},   int'(bus.key_code), m_code);
    chk({tag, "_cnt"},    int'(bus.digit_count), m_cnt);
    chk({tag, "_num"},    int'(bus.number_out), m_num);
    chk({tag, "_nv"},     int'(bus.number_valid), m_nv);
  endtask

  typedef struct {
    bit ack; logic [3:0] row; logic [3:0] col; int hold;
    int str; int code; int op; int err; int cnt; int num; int nv;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[17];
    int n_ack, n_str, n_op, n_err, e_str, e_op, e_err;

    bus.pressed_row_in = '0;
    bus.pressed_col_in = '0;
    bus.pressed_valid  = 1'b0;
    bus.number_ack     = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack",    int'(bus.ack_read), 0);
    chk("rst_code",   int'(bus.key_code), 0);
    chk("rst_strobe", int'(bus.key_strobe), 0);
    chk("rst_op",     int'(bus.op_strobe), 0);
    chk("rst_num",    int'(bus.number_out), 0);
    chk("rst_nv",     int'(bus.number_valid), 0);
    chk("rst_cnt",    int'(bus.digit_count), 0);
    chk("rst_err",    int'(bus.key_error), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ack row col hold | str code op err cnt num nv
    tbl[0]  = '{0, oh(0), oh(0), 5,  1, 1,  0, 0, 1, 0,   0};
    tbl[1]  = '{0, oh(0), oh(1), 5,  1, 2,  0, 0, 2, 0,   0};
    tbl[2]  = '{0, oh(0), oh(2), 5,  1, 3,  0, 0, 3, 0,   0};
    tbl[3]  = '{0, oh(3), oh(2), 5,  1, 15, 0, 0, 0, 123, 1};
    tbl[4]  = '{1, oh(2), oh(2), 1,  1, 9,  0, 0, 1, 123, 0};
    tbl[5]  = '{0, oh(2), oh(2), 1,  1, 9,  0, 0, 2, 123, 0};
    tbl[6]  = '{0, oh(2), oh(2), 1,  1, 9,  0, 0, 3, 123, 0};
    tbl[7]  = '{0, oh(1), oh(0), 1,  1, 4,  0, 1, 3, 123, 0};
    tbl[8]  = '{0, oh(3), oh(2), 1,  1, 15, 0, 0, 0, 999, 1};
    tbl[9]  = '{1, oh(1), oh(1), 2,  1, 5,  0, 0, 1, 999, 0};
    tbl[10] = '{0, oh(3), oh(0), 2,  1, 14, 0, 0, 0, 999, 0};
    tbl[11] = '{0, oh(2), oh(0), 2,  1, 7,  0, 0, 1, 999, 0};
    tbl[12] = '{0, oh(3), oh(2), 2,  1, 15, 0, 0, 0, 7,   1};
    tbl[13] = '{0, oh(0), oh(3), 3,  1, 10, 1, 0, 0, 7,   1};
    tbl[14] = '{0, 4'b0011, 4'b0001, 3, 0, 10, 0, 1, 0, 7, 1};
    tbl[15] = '{0, oh(3), oh(2), 3,  1, 15, 0, 1, 0, 7,   1};
    tbl[16] = '{0, oh(3), oh(3), 50, 1, 13, 1, 0, 0, 7,   1};

    foreach (tbl[i]) begin
      if (tbl[i].ack) begin
        @(negedge clk); bus.number_ack = 1'b1;
        @(negedge clk); bus.number_ack = 1'b0;
        m_nv = 0;
      end
      press(tbl[i].row, tbl[i].col, tbl[i].hold, n_ack, n_str, n_op, n_err);
      model_press(tbl[i].row, tbl[i].col, e_str, e_op, e_err);
      chk($sformatf("tbl%0d_ack", i),    n_ack, 1);
      chk($sformatf("tbl%0d_strobe", i), n_str, tbl[i].str);
      chk($sformatf("tbl%0d_op", i),     n_op, tbl[i].op);
      chk($sformatf("tbl%0d_err", i),    n_err, tbl[i].err);
      chk($sformatf("tbl%0d_code", i),   int'(bus.key_code), tbl[i].code);
      chk($sformatf("tbl%0d_cnt", i),    int'(bus.digit_count), tbl[i].cnt);
      chk($sformatf("tbl%0d_num", i),    int'(bus.number_out), tbl[i].num);
      chk($sformatf("tbl%0d_nv", i),     int'(bus.number_valid), tbl[i].nv);
    end

    // number_ack clears number_valid on the next edge; number_out holds
    @(negedge clk); bus.number_ack = 1'b1;
    chk("ack_pre_nv", int'(bus.number_valid), 1);
    @(negedge clk); bus.number_ack = 1'b0;
    chk("ack_clr_nv",  int'(bus.number_valid), 0);
    chk("ack_hold_num", int'(bus.number_out), 7);
    m_nv = 0;
    // ack with nothing pending is ignored
    @(negedge clk); bus.number_ack = 1'b1;
    @(negedge clk); bus.number_ack = 1'b0;
    @(negedge clk);
    chk("ack_idle_nv",  int'(bus.number_valid), 0);
    chk("ack_idle_num", int'(bus.number_out), 7);

    // '#' commit coinciding with number_ack: ack first, commit accepted
    press_model(oh(0), oh(0), 1, "co_d1");
    press_model(oh(3), oh(2), 1, "co_h1");
    press_model(oh(1), oh(2), 1, "co_d6");
    @(negedge clk);
    bus.pressed_row_in = oh(3); bus.pressed_col_in = oh(2); bus.pressed_valid = 1'b1;
    @(negedge clk);
    chk("co_ackread", int'(bus.ack_read), 1);
    bus.number_ack = 1'b1; bus.pressed_valid = 1'b0;
    @(negedge clk);
    bus.number_ack = 1'b0;
    chk("co_nv",     int'(bus.number_valid), 1);
    chk("co_num",    int'(bus.number_out), 6);
    chk("co_err",    int'(bus.key_error), 0);
    chk("co_strobe", int'(bus.key_strobe), 1);
    chk("co_cnt",    int'(bus.digit_count), 0);
    m_nv = 0;
    model_press(oh(3), oh(2), e_str, e_op, e_err);
    repeat (4) @(negedge clk);

    // Reset during ACK with 4, 2 accumulated
    press_model(oh(1), oh(0), 1, "rs_d4");
    press_model(oh(0), oh(1), 1, "rs_d2");
    @(negedge clk);
    bus.pressed_row_in = oh(1); bus.pressed_col_in = oh(1); bus.pressed_valid = 1'b1;
    @(negedge clk);
    chk("rs_pre_ack", int'(bus.ack_read), 1);
    chk("rs_pre_cnt", int'(bus.digit_count), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_ack", int'(bus.ack_read), 0);
    chk("rs_cnt", int'(bus.digit_count), 0);
    chk("rs_nv",  int'(bus.number_valid), 0);
    bus.pressed_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    press(oh(3), oh(2), 1, n_ack, n_str, n_op, n_err);
    chk("rs_hash_ack", n_ack, 1);
    chk("rs_hash_err", n_err, 1);
    chk("rs_hash_nv",  int'(bus.number_valid), 0);
    model_press(oh(3), oh(2), e_str, e_op, e_err);

    // Randomized presses against the model
    for (int t = 0; t < 200; t++) begin
      logic [3:0] r, c;
      int hold, pick;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); bus.number_ack = 1'b1;
        @(negedge clk); bus.number_ack = 1'b0;
        m_nv = 0;
      end
      pick = int'($urandom_range(0, 9));
      if (pick == 0) begin
        r = 4'($urandom); c = 4'($urandom);
      end else if (pick <= 2) begin
        r = oh(3); c = oh(2);
      end else begin
        r = oh(int'($urandom_range(0, 3))); c = oh(int'($urandom_range(0, 3)));
      end
      hold = int'($urandom_range(1, 6));
      press_model(r, c, hold, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/captura_de_numero.md
Name: captura_de_numero

Overview:
- Consumer at the far end of the keypad scanner's latched-key handshake.
- Samples the scanner's one-hot column/row pair while pressed_valid is high, and returns a single-cycle ack_read to release the scanner's latch.
- Decodes the key to a 4-bit code and accumulates decimal digits into a binary operand.
- Presents the operand on a valid/ack interface to downstream arithmetic/display logic; letter keys are forwarded as operator strobes.

Parameters:
- WIDTH, 4, keypad rows = columns; one-hot bus width.
- MAX_DIGITS, 3, maximum decimal digits per operand.
- VALUE_W, 10, operand width. Must satisfy 2^VALUE_W > 10^MAX_DIGITS − 1; the elaboration-time check fails otherwise.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- pressed_col_in  in  WIDTH  one-hot column from scanner.
- pressed_row_in  in  WIDTH  one-hot row from scanner.
- pressed_valid  in  1  scanner has a latched key.
- ack_read  out  1  one-cycle release pulse to scanner.
- key_code  out  4  last decoded key code.
- key_strobe  out  1  one-cycle pulse: key_code updated.
- op_strobe  out  1  one-cycle pulse: letter key A–D accepted.
- number_out  out  VALUE_W  committed operand.
- number_valid  out  1  number_out holds an unconsumed operand.
- number_ack  in  1  downstream consumed number_out.
- digit_count  out  clog2(MAX_DIGITS+1)  digits in the current accumulator.
- key_error  out  1  one-cycle pulse: key rejected.

Behaviour:
- Reset, asynchronous on rst_n low: all outputs 0, accumulator 0, state IDLE. Reset asserted mid-handshake aborts it; ack_read goes low immediately.
- Key map (row,col → code):
  - Row 0: 1, 2, 3, A.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: *, 0, #, D.
  - Codes: digits 0–9 = value; A–D = 10–13; * = 14; # = 15.
- Row/col index comes from a one-hot encoder. Zero or multi-hot on either bus marks the key invalid.
- FSM states: IDLE, ACK, APPLY, RELEASE.
  - IDLE: at the edge where pressed_valid=1, register row/col, decoded code and invalid flag; go to ACK.
  - ACK: ack_read=1 for exactly this cycle (registered, so visible the cycle after capture); go to APPLY.
  - APPLY: execute the key, then go to RELEASE.
  - RELEASE: stay until pressed_valid=0, then IDLE. A key held valid never double-captures.
- Capture-to-effect latency: ack_read 1 cycle after the capture edge; key_strobe/op_strobe/number_valid 2 cycles after.
- APPLY actions (key_strobe=1 and key_code updated for every valid key):
  - Digit, count<MAX_DIGITS: acc ← acc·10 + d (computed as acc·8 + acc·2 at VALUE_W+4 bits, truncated), count+1.
  - Digit, count=MAX_DIGITS: accumulator unchanged, key_error=1.
  - *: acc ← 0, count ← 0.
  - #, count>0 and number_valid=0: number_out ← acc, number_valid ← 1, acc ← 0, count ← 0.
  - #, count=0 or number_valid=1: no change, key_error=1.
  - A–D: op_strobe=1, accumulator unchanged.
  - Invalid key: ack still issued, key_strobe=0, key_error=1.
- number_valid: set only by an accepted #; cleared on the edge where number_ack=1. If # commit and number_ack coincide on the same edge, the ack is applied first, so the commit is accepted and number_valid stays 1 with the new value. number_out holds its value until the next commit.
- number_ack while number_valid=0 is ignored.
- pressed_valid dropping during ACK or APPLY does not abort; RELEASE exits on the next cycle.

Decomposition:
- Package captura_pkg holds:
  - state enum {IDLE, ACK, APPLY, RELEASE};
  - key-code localparams (KEY_A=10 … KEY_STAR=14, KEY_HASH=15);
  - the 4×4 code lookup function.
- Sub-module: decodificador_tecla, combinational. Inputs are the one-hot row/col; outputs are code[3:0] and an invalid flag. Reused by the display path.

Test Plan:
- Press 1, 2, 3, # with pressed_valid held 5 cycles each and the scanner clearing on ack_read → three key_strobes with codes 1, 2, 3, 15; number_out=123, number_valid=1, digit_count returns to 0.
- Press 9, 9, 9, 4, # → the 4 raises key_error with digit_count staying 3; number_out=999.
- Press 5, *, 7, # → number_out=7; then number_ack=1 for one cycle → number_valid=0 on the next edge.
- Press row 0, col 3 (A) → op_strobe=1, key_code=10, accumulator unchanged. Press row=0011, col=0001 → ack_read pulses, key_error=1, key_strobe=0.
- Hold pressed_valid=1 for 50 cycles on a single key → exactly one ack_read and one key_strobe; second capture only after valid falls and rises again.
- Assert rst_n=0 during ACK with digits 4, 2 accumulated → ack_read=0 and digit_count=0 immediately. After release, pressing # → key_error=1, number_valid stays 0.
